// File: rtl/comparator_serial_signed.sv
// ---------------------------------------------------------------------------
// comparator_serial_signed
//
// Bit-serial magnitude comparator. Examines one bit per clock, MSB first,
// and reports whether A is greater than, equal to, or less than B, using
// either an unsigned or a two's-complement interpretation.
//
// Ports:
//   clk          - sole clock, rising edge
//   rst_n        - asynchronous active-low reset
//   start        - request a comparison (sampled only while not busy)
//   signed_mode  - 1 = two's-complement compare, 0 = unsigned; captured with start
//   A, B         - operands, captured with start
//   busy         - high while the scan is in progress
//   done         - one-cycle pulse when the result outputs have just updated
//   A_GREATER_B  - registered result, A > B
//   A_EQUAL_B    - registered result, A == B
//   A_LESS_B     - registered result, A < B
//
// Configuration:
//   COMP_SERIAL_EARLY_EXIT_EN - when defined, the scan stops on the first
//   differing bit instead of always walking down to bit 0. Results are the
//   same in both builds; only the latency changes.
// ---------------------------------------------------------------------------
module comparator_serial_signed #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_GREATER_B,
  output logic             A_EQUAL_B,
  output logic             A_LESS_B
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             decided_q, decided_d;
  logic             dec_gt_q, dec_gt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic bit_diff;
  logic bit_greater;
  logic at_msb;
  logic last_bit;
  logic scan_exit;

  // Per-bit decision. When the bits differ, A's bit alone tells us who is
  // larger; in signed mode the sign bit has negative weight, so the sense
  // of the decision flips at the MSB.
  always_comb begin
    at_msb      = (idx_q == IW'(WIDTH - 1));
    last_bit    = (idx_q == '0);
    bit_diff    = a_q[idx_q] ^ b_q[idx_q];
    bit_greater = a_q[idx_q] ^ (signed_q & at_msb);
`ifdef COMP_SERIAL_EARLY_EXIT_EN
    scan_exit   = last_bit | bit_diff;
`else
    scan_exit   = last_bit;
`endif
  end

  // Next-state logic. The first differing bit is latched in decided/dec_gt
  // so the full-length scan can keep walking without losing the answer;
  // the visible result registers only change on the SCAN->DONE edge.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    signed_d  = signed_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    dec_gt_d  = dec_gt_q;
    gt_d      = gt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d       = A;
          b_d       = B;
          signed_d  = signed_mode;
          idx_d     = IW'(WIDTH - 1);
          decided_d = 1'b0;
          dec_gt_d  = 1'b0;
          state_d   = SCAN;
        end else begin
          state_d = IDLE;
        end
      end

      SCAN: begin
        if (!decided_q && bit_diff) begin
          decided_d = 1'b1;
          dec_gt_d  = bit_greater;
        end
        if (scan_exit) begin
          state_d = DONE;
          if (decided_q) begin
            gt_d = dec_gt_q;
            eq_d = 1'b0;
            lt_d = ~dec_gt_q;
          end else if (bit_diff) begin
            gt_d = bit_greater;
            eq_d = 1'b0;
            lt_d = ~bit_greater;
          end else begin
            gt_d = 1'b0;
            eq_d = 1'b1;
            lt_d = 1'b0;
          end
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything immediately,
  // which also silently abandons any comparison in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      dec_gt_q  <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      signed_q  <= signed_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      dec_gt_q  <= dec_gt_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
    end
  end

  assign busy        = (state_q == SCAN);
  assign done        = (state_q == DONE);
  assign A_GREATER_B = gt_q;
  assign A_EQUAL_B   = eq_q;
  assign A_LESS_B    = lt_q;

endmodule

// File: tb/tb_comparator_serial_signed.sv
// ---------------------------------------------------------------------------
// tb_comparator_serial_signed
//
// Self-checking bench for comparator_serial_signed (WIDTH=8). Expected
// results come from plain signed/unsigned integer comparison; expected
// latency comes from the position of the highest differing bit. Edge 1 is
// the edge that samples start.
// ---------------------------------------------------------------------------
module tb_comparator_serial_signed;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic         A_GREATER_B;
  logic         A_EQUAL_B;
  logic         A_LESS_B;

  int vectors;
  int miscompares;

  comparator_serial_signed #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .A_GREATER_B (A_GREATER_B),
    .A_EQUAL_B   (A_EQUAL_B),
    .A_LESS_B    (A_LESS_B)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference result as {gt, eq, lt} from ordinary integer comparison
  function automatic logic [2:0] modelResult(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    int va;
    int vb;
    if (s) begin
      va = int'($signed(a));
      vb = int'($signed(b));
    end else begin
      va = int'(a);
      vb = int'(b);
    end
    return {va > vb, va == vb, va < vb};
  endfunction

  // Reference latency in edges, counting the start-sampling edge as 1
  function automatic int modelLatency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef COMP_SERIAL_EARLY_EXIT_EN
    for (int k = W - 1; k >= 0; k--) begin
      if (a[k] != b[k]) return (W - 1 - k) + 2;
    end
    return W + 1;
`else
    if (a == b) return W + 1;
    return W + 1;
`endif
  endfunction

  // Present operands and a one-cycle start; returns #1 after edge 1 with
  // the operand inputs scrambled so late changes would be noticed.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    A           = a;
    B           = b;
    signed_mode = s;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    A           = W'($urandom);
    B           = W'($urandom);
    signed_mode = 1'(($urandom));
  endtask

  // Step edges until done is seen; edges tracks the running edge count
  task automatic waitDone(inout int edges, output bit timedOut);
    timedOut = 1'b0;
    while (1) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) break;
      if (edges > 40) begin
        timedOut = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    A           = '0;
    B           = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, A_GREATER_B, A_EQUAL_B, A_LESS_B} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %b expected 00000",
               {busy, done, A_GREATER_B, A_EQUAL_B, A_LESS_B});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full comparison with result, latency and single-cycle-done checks
  task automatic runAndCheck(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic s, input logic [2:0] prevRes);
    int       edges;
    bit       timedOut;
    logic [2:0] expRes;
    expRes = modelResult(a, b, s);
    applyStimulus(a, b, s);
    vectors++;
    if (busy !== 1'b1 || {A_GREATER_B, A_EQUAL_B, A_LESS_B} !== prevRes) begin
      miscompares++;
      $display("[TB] FAIL %s_scan_hold: busy=%b res=%b expected busy=1 res=%b",
               name, busy, {A_GREATER_B, A_EQUAL_B, A_LESS_B}, prevRes);
    end
    edges = 1;
    waitDone(edges, timedOut);
    vectors++;
    if (timedOut) begin
      miscompares++;
      $display("[TB] FAIL %s_timeout: no done within %0d edges", name, edges);
    end else if ({A_GREATER_B, A_EQUAL_B, A_LESS_B} !== expRes ||
                 edges != modelLatency(a, b) || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s: A=%h B=%h s=%b res=%b edge=%0d busy=%b expected res=%b edge=%0d",
               name, a, b, s, {A_GREATER_B, A_EQUAL_B, A_LESS_B}, edges, busy,
               expRes, modelLatency(a, b));
    end
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || {A_GREATER_B, A_EQUAL_B, A_LESS_B} !== expRes) begin
      miscompares++;
      $display("[TB] FAIL %s_after: done=%b busy=%b res=%b expected 0 0 %b",
               name, done, busy, {A_GREATER_B, A_EQUAL_B, A_LESS_B}, expRes);
    end
  endtask

  task automatic test_directed;
    runAndCheck("signed_min_vs_max", 8'h80, 8'h7F, 1'b1, 3'b000);
    runAndCheck("unsigned_80_7f",    8'h80, 8'h7F, 1'b0, 3'b001);
    runAndCheck("signed_ff_fe",      8'hFF, 8'hFE, 1'b1, 3'b100);
    runAndCheck("equal_unsigned",    8'h5A, 8'h5A, 1'b0, 3'b100);
    runAndCheck("equal_signed",      8'h5A, 8'h5A, 1'b1, 3'b010);
    runAndCheck("unsigned_00_ff",    8'h00, 8'hFF, 1'b0, 3'b010);
    runAndCheck("lsb_only",          8'h41, 8'h40, 1'b1, 3'b001);
  endtask

  task automatic test_random;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [2:0]   prev;
    prev = {A_GREATER_B, A_EQUAL_B, A_LESS_B};
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = (i % 5 == 0) ? a : W'($urandom);
      s = 1'($urandom);
      runAndCheck("random", a, b, s, prev);
      prev = modelResult(a, b, s);
    end
  endtask

  task automatic test_ignore_start;
    int edges;
    bit timedOut;
    applyStimulus(8'h01, 8'h02, 1'b0);
    @(posedge clk);
    @(negedge clk);
    A           = 8'hFF;
    B           = 8'h00;
    signed_mode = 1'b1;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = 8'h33;
    B     = 8'hC4;
    edges = 3;
    waitDone(edges, timedOut);
    vectors++;
    if (timedOut || {A_GREATER_B, A_EQUAL_B, A_LESS_B} !== 3'b001 ||
        edges != modelLatency(8'h01, 8'h02)) begin
      miscompares++;
      $display("[TB] FAIL ignore_start: res=%b edge=%0d expected res=001 edge=%0d",
               {A_GREATER_B, A_EQUAL_B, A_LESS_B}, edges, modelLatency(8'h01, 8'h02));
    end
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ignore_start_idle: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    int         edges;
    bit         timedOut;
    logic [2:0] firstRes;
    logic [W-1:0] a2;
    logic [W-1:0] b2;
    firstRes = modelResult(8'h10, 8'h90, 1'b1);
    applyStimulus(8'h10, 8'h90, 1'b1);
    edges = 1;
    waitDone(edges, timedOut);
    a2 = W'($urandom);
    b2 = W'($urandom);
    A           = a2;
    B           = b2;
    signed_mode = 1'b0;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = ~a2;
    B     = ~b2;
    vectors++;
    if (timedOut || busy !== 1'b1 || {A_GREATER_B, A_EQUAL_B, A_LESS_B} !== firstRes) begin
      miscompares++;
      $display("[TB] FAIL back_to_back_start: busy=%b res=%b expected busy=1 res=%b",
               busy, {A_GREATER_B, A_EQUAL_B, A_LESS_B}, firstRes);
    end
    edges = 1;
    waitDone(edges, timedOut);
    vectors++;
    if (timedOut || {A_GREATER_B, A_EQUAL_B, A_LESS_B} !== modelResult(a2, b2, 1'b0) ||
        edges != modelLatency(a2, b2)) begin
      miscompares++;
      $display("[TB] FAIL back_to_back_result: res=%b edge=%0d expected res=%b edge=%0d",
               {A_GREATER_B, A_EQUAL_B, A_LESS_B}, edges, modelResult(a2, b2, 1'b0),
               modelLatency(a2, b2));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_scan;
    bit sawDone;
    applyStimulus(8'h00, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, A_GREATER_B, A_EQUAL_B, A_LESS_B} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_scan: got %b expected 00000",
               {busy, done, A_GREATER_B, A_EQUAL_B, A_LESS_B});
    end
    @(negedge clk);
    rst_n   = 1'b1;
    sawDone = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) sawDone = 1'b1;
    end
    vectors++;
    if (sawDone) begin
      miscompares++;
      $display("[TB] FAIL reset_no_done: got done pulse expected none");
    end
    runAndCheck("after_reset", 8'hC3, 8'h3C, 1'b1, 3'b000);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
